// File: rtl/maquina_estados_pet_if.sv
// rtl/maquina_estados_pet_if.sv - player buttons, attribute inputs and state/alert outputs of the pet sequencer
interface maquina_estados_pet_if;
    logic       btn_start;
    logic       btn_dormir;
    logic       btn_comer;
    logic       btn_aula;
    logic       btn_cancelar;
    logic [7:0] fome;
    logic [7:0] felicidade;
    logic [7:0] sono;
    logic [4:0] estado;
    logic [2:0] alerta;

    modport master (
        output btn_start, btn_dormir, btn_comer, btn_aula, btn_cancelar,
        output fome, felicidade, sono,
        input  estado, alerta
    );

    modport slave (
        input  btn_start, btn_dormir, btn_comer, btn_aula, btn_cancelar,
        input  fome, felicidade, sono,
        output estado, alerta
    );
endinterface

// File: rtl/maquina_estados_pet.sv
// rtl/maquina_estados_pet.sv - pet behaviour sequencer: edge-detected commands, one-hot state, low-attribute alerts
module maquina_estados_pet #(
    parameter int MAX_ATRIB     = 100,
    parameter int LIMIAR_ALERTA = 20,
    parameter int DURACAO_MAX   = 50000000,
    parameter int LARGURA_CONT  = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    maquina_estados_pet_if.slave bus
);
    typedef enum logic [4:0] {
        S_INTRO      = 5'b00000,
        S_IDLE       = 5'b00001,
        S_DORMINDO   = 5'b00010,
        S_COMENDO    = 5'b00100,
        S_DANDO_AULA = 5'b01000,
        S_MORTO      = 5'b10000
    } estado_t;

    localparam logic [7:0]              MAX8    = 8'(MAX_ATRIB);
    localparam logic [7:0]              LIMIAR8 = 8'(LIMIAR_ALERTA);
    localparam logic [LARGURA_CONT-1:0] CONT_FIM = LARGURA_CONT'(DURACAO_MAX - 1);

    estado_t                 estado_q, estado_d;
    logic [LARGURA_CONT-1:0] cont_q, cont_d;
    logic [2:0]              alerta_q, alerta_d;
    logic [4:0]              btn_q;
    logic [4:0]              btn_now;
    logic [4:0]              press;
    logic                    morte;
    logic                    fim_comum;
    logic                    atividade;

    // Bit order: {start, dormir, comer, aula, cancelar}
    assign btn_now   = {bus.btn_start, bus.btn_dormir, bus.btn_comer, bus.btn_aula, bus.btn_cancelar};
    assign press     = btn_now & ~btn_q;
    assign morte     = (bus.fome == 8'd0) | (bus.felicidade == 8'd0) | (bus.sono == 8'd0);
    assign fim_comum = press[0] | (cont_q == CONT_FIM);
    assign atividade = (estado_q == S_DORMINDO) | (estado_q == S_COMENDO) | (estado_q == S_DANDO_AULA);

    always_comb begin
        estado_d = estado_q;
        cont_d   = '0;
        case (estado_q)
            S_INTRO:      if (press[4]) estado_d = S_IDLE;
            S_IDLE: begin
                if (morte)         estado_d = S_MORTO;
                else if (press[3]) estado_d = S_DORMINDO;
                else if (press[2]) estado_d = S_COMENDO;
                else if (press[1]) estado_d = S_DANDO_AULA;
            end
            S_DORMINDO: begin
                if (morte)                               estado_d = S_MORTO;
                else if (fim_comum || bus.sono >= MAX8)  estado_d = S_IDLE;
            end
            S_COMENDO: begin
                if (morte)                               estado_d = S_MORTO;
                else if (fim_comum || bus.fome >= MAX8)  estado_d = S_IDLE;
            end
            S_DANDO_AULA: begin
                if (morte)                                     estado_d = S_MORTO;
                else if (fim_comum || bus.felicidade >= MAX8)  estado_d = S_IDLE;
            end
            S_MORTO:      if (press[4]) estado_d = S_INTRO;
            default:      estado_d = S_INTRO;
        endcase

        if (atividade && estado_d == estado_q) cont_d = cont_q + 1'b1;

        // Alerts follow the state being entered so MORTO/INTRO show 000 from their first cycle
        if (estado_d == S_INTRO || estado_d == S_MORTO)
            alerta_d = 3'b000;
        else
            alerta_d = {bus.fome < LIMIAR8, bus.sono < LIMIAR8, bus.felicidade < LIMIAR8};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= S_INTRO;
            cont_q   <= '0;
            alerta_q <= 3'b000;
            btn_q    <= 5'b00000;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            alerta_q <= alerta_d;
            btn_q    <= btn_now;
        end
    end

    assign bus.estado = estado_q;
    assign bus.alerta = alerta_q;
endmodule

// File: tb/tb_maquina_estados_pet.sv
// tb/tb_maquina_estados_pet.sv - directed scoreboard bench for maquina_estados_pet
module tb_maquina_estados_pet;
    localparam logic [4:0] E_INTRO = 5'b00000;
    localparam logic [4:0] E_IDLE  = 5'b00001;
    localparam logic [4:0] E_DORM  = 5'b00010;
    localparam logic [4:0] E_COME  = 5'b00100;
    localparam logic [4:0] E_AULA  = 5'b01000;
    localparam logic [4:0] E_MORTO = 5'b10000;

    typedef struct {
        string      tag;
        logic [4:0] est;
        logic [2:0] al;
    } exp_t;

    logic clk;
    logic rst;
    maquina_estados_pet_if ifc ();

    maquina_estados_pet #(
        .MAX_ATRIB     (100),
        .LIMIAR_ALERTA (20),
        .DURACAO_MAX   (8),
        .LARGURA_CONT  (26)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [4:0] e_obs, input logic [4:0] e_exp,
                           input logic [2:0] a_obs, input logic [2:0] a_exp);
        n_total++;
        assert (e_obs === e_exp && a_obs === a_exp) n_pass++;
        else $error("FAIL %s: estado=%b alerta=%b required estado=%b alerta=%b",
                    tag, e_obs, a_obs, e_exp, a_exp);
    endtask

    task automatic expect_edge(input string tag, input logic [4:0] e, input logic [2:0] a);
        exp_t x;
        x.tag = tag;
        x.est = e;
        x.al  = a;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        compare(x.tag, ifc.estado, x.est, ifc.alerta, x.al);
    endtask

    task automatic set_attr(input logic [7:0] f, input logic [7:0] h, input logic [7:0] s);
        ifc.fome       = f;
        ifc.felicidade = h;
        ifc.sono       = s;
    endtask

    initial begin
        rst = 1'b1;
        ifc.btn_start = 0; ifc.btn_dormir = 0; ifc.btn_comer = 0;
        ifc.btn_aula = 0;  ifc.btn_cancelar = 0;
        set_attr(8'd80, 8'd50, 8'd70);
        #3;
        compare("reset", ifc.estado, E_INTRO, ifc.alerta, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        expect_edge("intro_idle", E_INTRO, 3'b000);

        ifc.btn_start = 1;
        expect_edge("start_press", E_IDLE, 3'b000);
        for (int i = 0; i < 10; i++) expect_edge("start_held", E_IDLE, 3'b000);
        ifc.btn_start = 0;

        ifc.btn_dormir = 1; ifc.btn_comer = 1; ifc.sono = 8'd99;
        expect_edge("dormir_prio", E_DORM, 3'b000);
        for (int i = 0; i < 5; i++) expect_edge("dormir_sono99", E_DORM, 3'b000);
        ifc.sono = 8'd100;
        expect_edge("dormir_full", E_IDLE, 3'b000);
        ifc.btn_dormir = 0; ifc.btn_comer = 0; ifc.sono = 8'd70;
        expect_edge("idle_after_sleep", E_IDLE, 3'b000);

        ifc.btn_aula = 1;
        expect_edge("aula_enter", E_AULA, 3'b000);
        for (int i = 0; i < 7; i++) expect_edge("aula_running", E_AULA, 3'b000);
        expect_edge("aula_timeout", E_IDLE, 3'b000);
        expect_edge("aula_held_no_repress", E_IDLE, 3'b000);
        ifc.btn_aula = 0;

        ifc.btn_comer = 1; ifc.btn_aula = 1;
        expect_edge("comer_over_aula", E_COME, 3'b000);
        ifc.btn_comer = 0; ifc.btn_aula = 0;
        expect_edge("comer_run", E_COME, 3'b000);
        ifc.btn_cancelar = 1;
        expect_edge("cancel", E_IDLE, 3'b000);
        ifc.btn_cancelar = 0;
        expect_edge("idle_after_cancel", E_IDLE, 3'b000);

        ifc.btn_dormir = 1;
        expect_edge("dormir2", E_DORM, 3'b000);
        ifc.btn_dormir = 0; ifc.sono = 8'd200;
        expect_edge("sono_above_max", E_IDLE, 3'b000);
        ifc.sono = 8'd70;

        ifc.btn_comer = 1;
        expect_edge("comer2", E_COME, 3'b000);
        ifc.btn_comer = 0;
        expect_edge("comer2_run", E_COME, 3'b000);
        ifc.fome = 8'd100; ifc.sono = 8'd0;
        expect_edge("death_over_full", E_MORTO, 3'b000);
        ifc.btn_comer = 1;
        expect_edge("morto_ignores_comer", E_MORTO, 3'b000);
        ifc.btn_comer = 0; ifc.btn_start = 1;
        expect_edge("morto_restart", E_INTRO, 3'b000);
        ifc.btn_start = 0;
        for (int i = 0; i < 3; i++) expect_edge("intro_ignores_morte", E_INTRO, 3'b000);

        set_attr(8'd80, 8'd50, 8'd70);
        ifc.btn_start = 1;
        expect_edge("start_again", E_IDLE, 3'b000);
        ifc.btn_start = 0;
        ifc.fome = 8'd20;
        expect_edge("fome_at_limit", E_IDLE, 3'b000);
        ifc.fome = 8'd19;
        expect_edge("fome_below_limit", E_IDLE, 3'b100);
        ifc.fome = 8'd15;
        #1;
        compare("alert_latency", ifc.estado, E_IDLE, ifc.alerta, 3'b100);
        ifc.sono = 8'd10; ifc.felicidade = 8'd5;
        #1;
        compare("alert_not_yet", ifc.estado, E_IDLE, ifc.alerta, 3'b100);
        expect_edge("all_alerts", E_IDLE, 3'b111);
        ifc.felicidade = 8'd30;
        expect_edge("fome_sono_alerts", E_IDLE, 3'b110);
        ifc.fome = 8'd0;
        expect_edge("idle_death", E_MORTO, 3'b000);
        ifc.btn_start = 1;
        expect_edge("restart2", E_INTRO, 3'b000);
        ifc.btn_start = 0;
        set_attr(8'd80, 8'd50, 8'd70);
        expect_edge("intro_wait", E_INTRO, 3'b000);
        ifc.btn_start = 1;
        expect_edge("start3", E_IDLE, 3'b000);
        ifc.btn_start = 0;

        ifc.btn_dormir = 1;
        expect_edge("dormir3", E_DORM, 3'b000);
        #2;
        rst = 1'b1;
        #1;
        compare("async_reset", ifc.estado, E_INTRO, ifc.alerta, 3'b000);
        ifc.btn_dormir = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) expect_edge("post_reset_quiet", E_INTRO, 3'b000);
        ifc.btn_start = 1;
        expect_edge("post_reset_start", E_IDLE, 3'b000);
        ifc.btn_start = 0;
        ifc.btn_aula = 1;
        expect_edge("post_reset_aula", E_AULA, 3'b000);
        for (int i = 0; i < 7; i++) expect_edge("aula2_running", E_AULA, 3'b000);
        expect_edge("aula2_timeout_counter_cleared", E_IDLE, 3'b000);
        ifc.btn_aula = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
